// File: rtl/reg_file_16_pkg.sv
// rtl/reg_file_16_pkg.sv - shared register-file addressing constants
package reg_file_16_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT  = 16;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/mux_16to1.sv
// rtl/mux_16to1.sv - single-bit 16-way select used for each read-port bit
module mux_16to1 (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       i5,
  input  logic       i6,
  input  logic       i7,
  input  logic       i8,
  input  logic       i9,
  input  logic       i10,
  input  logic       i11,
  input  logic       i12,
  input  logic       i13,
  input  logic       i14,
  input  logic       i15,
  input  logic [3:0] sel,
  output logic       y
);

  logic [15:0] vec;

  assign vec = {i15, i14, i13, i12, i11, i10, i9, i8,
                i7, i6, i5, i4, i3, i2, i1, i0};
  assign y   = vec[sel];

endmodule

// File: rtl/reg_file_16.sv
// rtl/reg_file_16.sv - 16-entry register file, 1 sync write, 2 comb reads, r0 = 0
module reg_file_16
  import reg_file_16_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2
);

  logic [WIDTH-1:0]     regs [1:REG_COUNT-1];
  logic [REG_COUNT-1:1] wr_sel;
  logic [WIDTH-1:0]     mux1;
  logic [WIDTH-1:0]     mux2;
  logic                 hit1;
  logic                 hit2;

  // An X address makes every compare X, so no select line fires.
  always_comb begin
    wr_sel = '0;
    if (we) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (wa == REG_ADDR_W'(i)) begin
          wr_sel[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wd;
        end
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_read_bit
    mux_16to1 u_rd1 (
      .i0 (1'b0),        .i1 (regs[1][b]),  .i2 (regs[2][b]),  .i3 (regs[3][b]),
      .i4 (regs[4][b]),  .i5 (regs[5][b]),  .i6 (regs[6][b]),  .i7 (regs[7][b]),
      .i8 (regs[8][b]),  .i9 (regs[9][b]),  .i10(regs[10][b]), .i11(regs[11][b]),
      .i12(regs[12][b]), .i13(regs[13][b]), .i14(regs[14][b]), .i15(regs[15][b]),
      .sel(ra1),
      .y  (mux1[b])
    );
    mux_16to1 u_rd2 (
      .i0 (1'b0),        .i1 (regs[1][b]),  .i2 (regs[2][b]),  .i3 (regs[3][b]),
      .i4 (regs[4][b]),  .i5 (regs[5][b]),  .i6 (regs[6][b]),  .i7 (regs[7][b]),
      .i8 (regs[8][b]),  .i9 (regs[9][b]),  .i10(regs[10][b]), .i11(regs[11][b]),
      .i12(regs[12][b]), .i13(regs[13][b]), .i14(regs[14][b]), .i15(regs[15][b]),
      .sel(ra2),
      .y  (mux2[b])
    );
  end

  if (BYPASS != 0) begin : g_bypass
    assign hit1 = we && (wa != REG_ZERO) && (ra1 == wa);
    assign hit2 = we && (wa != REG_ZERO) && (ra2 == wa);
  end else begin : g_no_bypass
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
  end

  // Reset gating also masks the bypass path, which would otherwise leak wd.
  assign rd1 = reset ? '0 : (hit1 ? wd : mux1);
  assign rd2 = reset ? '0 : (hit2 ? wd : mux2);

endmodule

// File: tb/tb_reg_file_16.sv
// tb/tb_reg_file_16.sv - self-checking bench for reg_file_16 (bypass and non-bypass builds)
module tb_reg_file_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  reg_file_16 #(.WIDTH(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b)
  );

  reg_file_16 #(.WIDTH(32), .BYPASS(0)) dut_nob (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [3:0] ra, input bit byp);
    if (reset) return 32'h0;
    if (ra == 4'd0) return 32'h0;
    if (byp && we && wa == ra) return wd;
    return mem[ra];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endtask

  task automatic check_all(input string tag);
    #1;
    check({tag, "/byp_rd1"}, rd1_b, expect_rd(ra1, 1'b1));
    check({tag, "/byp_rd2"}, rd2_b, expect_rd(ra2, 1'b1));
    check({tag, "/nob_rd1"}, rd1_n, expect_rd(ra1, 1'b0));
    check({tag, "/nob_rd2"}, rd2_n, expect_rd(ra2, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && we && wa != 4'd0) mem[wa] = wd;
    #1;
  endtask

  task automatic sweep(input string tag);
    we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ra1 = 4'(k);
      ra2 = 4'(15 - k);
      check_all(tag);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = 4'd0; wd = 32'h0; ra1 = 4'd0; ra2 = 4'd0;
    clear_model();

    // reset state over every address, no edge needed
    for (int k = 0; k < 16; k++) begin
      ra1 = 4'(k); ra2 = 4'(k);
      check_all("reset_state");
    end
    @(negedge clk); #1 reset = 1'b0;

    // write/readback with a distinct pattern per entry
    for (int k = 1; k < 16; k++) begin
      we = 1'b1; wa = 4'(k); wd = 32'hA5A5_0000 + k; ra1 = 4'(k); ra2 = 4'd0;
      check_all("write_pre");
      tick();
    end
    we = 1'b0;
    for (int k = 1; k < 16; k++) begin
      ra1 = 4'(k); ra2 = 4'(16 - k);
      check_all("readback");
      check("readback_const", rd1_b, 32'hA5A5_0000 + k);
    end

    // reset mid-cycle clears everything asynchronously
    @(negedge clk); #2 reset = 1'b1;
    clear_model();
    for (int k = 0; k < 16; k++) begin
      ra1 = 4'(k); ra2 = 4'(15 - k); we = 1'b1; wa = 4'(k); wd = 32'hFFFF_0000 | k;
      check_all("reset_async");
    end
    we = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    for (int k = 1; k < 16; k++) write_reg(4'(k), 32'h0BAD_0000 + k);

    // zero register ignores writes
    we = 1'b1; wa = 4'd0; wd = 32'hFFFF_FFFF; ra1 = 4'd0; ra2 = 4'd7;
    check_all("zero_pre");
    check("zero_pre_const", rd1_b, 32'h0);
    tick();
    sweep("zero_post");

    // bypass vs stored value
    write_reg(4'd5, 32'h1111_1111);
    we = 1'b1; wa = 4'd5; wd = 32'h2222_2222; ra1 = 4'd5; ra2 = 4'd5;
    check_all("bypass_pre");
    check("bypass_on_pre", rd2_b, 32'h2222_2222);
    check("bypass_off_pre", rd2_n, 32'h1111_1111);
    tick();
    we = 1'b0;
    check_all("bypass_post");
    check("bypass_off_post", rd1_n, 32'h2222_2222);

    // reset beats a simultaneous write
    write_reg(4'd3, 32'hDEAD_BEEF);
    @(negedge clk); reset = 1'b1;
    clear_model();
    we = 1'b1; wa = 4'd3; wd = 32'h1234_5678; ra1 = 4'd3; ra2 = 4'd3;
    check_all("rst_vs_we_pre");
    tick();
    check_all("rst_vs_we_edge");
    check("rst_vs_we_const", rd1_n, 32'h0);
    @(negedge clk); #1 reset = 1'b0;
    check_all("rst_release");
    tick();
    check_all("rst_first_write");
    check("rst_first_write_const", rd1_n, 32'h1234_5678);
    we = 1'b0;

    // write disable over 10 edges
    for (int k = 1; k < 16; k++) write_reg(4'(k), $urandom);
    for (int n = 0; n < 10; n++) begin
      we = 1'b0; wa = 4'($urandom_range(0, 15)); wd = $urandom;
      tick();
    end
    sweep("we_low");

    // randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk); reset = 1'b1;
        clear_model();
        we = 1'b0;
        check_all("rand_reset");
        #2 reset = 1'b0;
      end
      we  = 1'($urandom_range(0, 3) != 0);
      wa  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      check_all("rand");
      tick();
    end
    sweep("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
